fixed_integrate_dump: RTL and testbench

- Integrate-and-dump accumulator for fixed-point samples.
- Sums LENGTH consecutive valid input samples at full precision, then emits one result and starts the next window.
- Sits directly upstream of fixed_rounder, which narrows its wide output to the required width.
- Shares the rounder's clock, clock enable and sign-representation conventions, so the two chain without glue logic.

---
 rtl/fixed_pkg.sv | 25 ++
 rtl/fixed_window_counter.sv | 32 +++
 rtl/fixed_integrate_dump.sv | 77 +++++++
 tb/tb_fixed_integrate_dump.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point helpers: sign-representation names, the legality check,
// accumulator width derivation and sample extension.
package fixed_pkg;

  localparam string SIGNREP_SIGNED   = "SIGNED";
  localparam string SIGNREP_UNSIGNED = "UNSIGNED";

  function automatic bit signrep_ok(string s);
    return (s == SIGNREP_SIGNED) || (s == SIGNREP_UNSIGNED);
  endfunction

  function automatic int acc_width(int iwidth, int length);
    return iwidth + $clog2(length);
  endfunction

  // Bits at and above 'width' come from the sign bit (signed) or zero.
  function automatic logic [63:0] ext(logic [63:0] data, int width, bit signed_flag);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++)
      r[i] = (i < width) ? data[i] : (signed_flag & data[width-1]);
    return r;
  endfunction

endpackage

// File: rtl/fixed_window_counter.sv
// Modulo-LENGTH sample counter with enable, synchronous reset,
// load-to-1 (window restart) and first/last position flags.
module fixed_window_counter
  import fixed_pkg::*;
#(
  parameter int LENGTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load1,
  output logic first,
  output logic last
);

  localparam int CW = $clog2(LENGTH);

  logic [CW-1:0] cnt;

  assign first = (cnt == '0);
  assign last  = (cnt == CW'(LENGTH - 1));

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load1)
      cnt <= CW'(1);
    else if (en)
      cnt <= last ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/fixed_integrate_dump.sv
// Integrate-and-dump accumulator: sums LENGTH valid samples at full precision.
// Optional window resync port i_sync when FIXED_INTEGRATE_DUMP_SYNC_EN is defined.
module fixed_integrate_dump
  import fixed_pkg::*;
#(
  parameter int    IWIDTH  = 7,
  parameter int    LENGTH  = 4,
  parameter string SIGNREP = "UNSIGNED",
  localparam int   OWIDTH  = acc_width(IWIDTH, LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkena,
`ifdef FIXED_INTEGRATE_DUMP_SYNC_EN
  input  logic              i_sync,
`endif
  input  logic              i_valid,
  input  logic [IWIDTH-1:0] i_data,
  output logic              o_valid,
  output logic [OWIDTH-1:0] o_data
);

  localparam bit IS_SIGNED = (SIGNREP == SIGNREP_SIGNED);

  generate
    if (!signrep_ok(SIGNREP)) begin : g_bad_signrep
      $error("fixed_integrate_dump: SIGNREP must be \"SIGNED\" or \"UNSIGNED\"");
    end
  endgenerate

  logic              take;
  logic              sync;
  logic              first;
  logic              last;
  logic [OWIDTH-1:0] x;
  logic [OWIDTH-1:0] acc;

  assign take = clkena & i_valid;
`ifdef FIXED_INTEGRATE_DUMP_SYNC_EN
  assign sync = take & i_sync;
`else
  assign sync = 1'b0;
`endif

  assign x = OWIDTH'(ext(64'(i_data), IWIDTH, IS_SIGNED));

  fixed_window_counter #(.LENGTH(LENGTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (take),
    .load1 (sync),
    .first (first),
    .last  (last)
  );

  // A sync sample restarts the window, so it both reloads acc and suppresses the dump.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (clkena) begin
      o_valid <= 1'b0;
      if (i_valid) begin
        if (first || sync)
          acc <= x;
        else
          acc <= acc + x;
        if (last && !sync) begin
          o_data  <= acc + x;
          o_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_integrate_dump.sv
// Bench for fixed_integrate_dump: unsigned and signed instances share stimulus and
// are checked every cycle against a window-of-samples model plus literal pins.
module tb_fixed_integrate_dump;

  localparam int IW = 7;
  localparam int LN = 4;
  localparam int OW = IW + $clog2(LN);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clkena = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_sync = 1'b0;
  logic [IW-1:0] i_data = '0;
  logic          u_valid, s_valid;
  logic [OW-1:0] u_data, s_data;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fixed_integrate_dump #(.IWIDTH(IW), .LENGTH(LN), .SIGNREP("UNSIGNED")) u_dut (
    .clk     (clk),
    .rst     (rst),
    .clkena  (clkena),
`ifdef FIXED_INTEGRATE_DUMP_SYNC_EN
    .i_sync  (i_sync),
`endif
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (u_valid),
    .o_data  (u_data)
  );

  fixed_integrate_dump #(.IWIDTH(IW), .LENGTH(LN), .SIGNREP("SIGNED")) s_dut (
    .clk     (clk),
    .rst     (rst),
    .clkena  (clkena),
`ifdef FIXED_INTEGRATE_DUMP_SYNC_EN
    .i_sync  (i_sync),
`endif
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (s_valid),
    .o_data  (s_data)
  );

  // Model: collect the accepted samples of the current window; when LENGTH are
  // present, their plain integer sum is the result.
  logic [IW-1:0] win[$];
  logic          exp_valid = 1'b0;
  logic [OW-1:0] exp_u = '0;
  logic [OW-1:0] exp_s = '0;

  always @(posedge clk) begin
    int su, ss;
    if (rst) begin
      win.delete();
      exp_valid <= 1'b0;
      exp_u <= '0;
      exp_s <= '0;
    end else if (clkena) begin
      exp_valid <= 1'b0;
      if (i_valid) begin
`ifdef FIXED_INTEGRATE_DUMP_SYNC_EN
        if (i_sync) win.delete();
`endif
        win.push_back(i_data);
        if (win.size() == LN) begin
          su = 0;
          ss = 0;
          foreach (win[k]) begin
            su += int'(win[k]);
            ss += int'($signed(win[k]));
          end
          exp_valid <= 1'b1;
          exp_u <= OW'(su);
          exp_s <= OW'(ss);
          win.delete();
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  logic run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp) begin
      check("u_valid", 32'(u_valid), 32'(exp_valid));
      check("u_data",  32'(u_data),  32'(exp_u));
      check("s_valid", 32'(s_valid), 32'(exp_valid));
      check("s_data",  32'(s_data),  32'(exp_s));
    end
  end

  // Drive one cycle of inputs, return after the posedge at the next negedge.
  task automatic step(input logic r, input logic ce, input logic v,
                      input logic [IW-1:0] d, input logic sy);
    rst = r;
    clkena = ce;
    i_valid = v;
    i_data = d;
    i_sync = sy;
    @(negedge clk);
  endtask

  task automatic window4(input int a, input int b, input int c, input int d);
    step(0, 1, 1, IW'(a), 0);
    step(0, 1, 1, IW'(b), 0);
    step(0, 1, 1, IW'(c), 0);
    step(0, 1, 1, IW'(d), 0);
  endtask

  initial begin
    @(negedge clk);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    run_cmp = 1'b1;
    step(0, 1, 0, 0, 0);
    check("reset_valid", 32'(u_valid), 32'd0);
    check("reset_data", 32'(u_data), 32'd0);

    window4(1, 2, 3, 4);
    check("sum_1234_valid", 32'(u_valid), 32'd1);
    check("sum_1234", 32'(u_data), 32'd10);
    step(0, 1, 0, 0, 0);
    check("pulse_one_cycle", 32'(u_valid), 32'd0);
    check("data_hold", 32'(u_data), 32'd10);

    window4(127, 127, 127, 127);
    check("unsigned_max", 32'(u_data), 32'd508);

    window4(5, 5, 5, 5);
    check("b2b_first", 32'(u_data), 32'd20);
    window4(6, 6, 6, 6);
    check("b2b_second", 32'(u_data), 32'd24);
    check("b2b_second_valid", 32'(u_valid), 32'd1);

    window4('h40, 'h40, 'h40, 'h40);
    check("signed_min", 32'(s_data), 32'h100);
    window4('h7f, 1, 'h7f, 1);
    check("signed_cancel", 32'(s_data), 32'd0);

    step(0, 1, 1, 1, 0); step(0, 1, 0, 0, 0);
    step(0, 1, 1, 2, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 1, 1, 3, 0); step(0, 1, 0, 0, 0);
    step(0, 1, 1, 4, 0);
    check("gaps_sum", 32'(u_data), 32'd10);
    check("gaps_valid", 32'(u_valid), 32'd1);

    window4(1, 2, 3, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 7'd50, 0);
      check("stall_valid_held", 32'(u_valid), 32'd1);
      check("stall_data_held", 32'(u_data), 32'd10);
    end
    step(0, 1, 0, 0, 0);
    check("after_stall_valid", 32'(u_valid), 32'd0);

    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 2, 0);
    step(0, 0, 1, 7'd50, 0);
    step(0, 0, 1, 7'd60, 0);
    step(0, 1, 1, 3, 0);
    step(0, 1, 1, 4, 0);
    check("stall_mid_window", 32'(u_data), 32'd10);

    step(0, 1, 1, 7, 0);
    step(0, 1, 1, 7, 0);
    step(1, 1, 0, 0, 0);
    check("midreset_data", 32'(u_data), 32'd0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    check("midreset_quiet", 32'(u_valid), 32'd0);
    check("midreset_quiet_data", 32'(u_data), 32'd0);
    step(0, 1, 1, 1, 0);
    check("midreset_sum", 32'(u_data), 32'd4);
    check("midreset_valid", 32'(u_valid), 32'd1);

`ifdef FIXED_INTEGRATE_DUMP_SYNC_EN
    step(0, 1, 1, 3, 0);
    step(0, 1, 1, 3, 0);
    step(0, 1, 1, 1, 1);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    check("sync_no_early", 32'(u_valid), 32'd0);
    step(0, 1, 1, 1, 0);
    check("sync_sum", 32'(u_data), 32'd4);
    check("sync_valid", 32'(u_valid), 32'd1);
    step(0, 1, 1, 2, 0);
    step(0, 1, 1, 2, 0);
    step(0, 1, 1, 2, 0);
    step(0, 1, 1, 2, 1);
    check("sync_last_no_pulse", 32'(u_valid), 32'd0);
    check("sync_last_data_hold", 32'(u_data), 32'd4);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 3, 0);
    step(0, 1, 1, 3, 0);
    step(0, 1, 1, 3, 0);
    check("sync_new_window", 32'(u_data), 32'd11);
`endif

    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
